// File: rtl/axis_full_to_data_c.sv
// AXI-Stream to data_inf_c register slice.
// Packs {tuser, tkeep, tlast, tdata} into one word through a two-entry skid buffer,
// so tready and the output valid/data are all driven straight from flops.
// Also counts accepted tlast beats and tracks whether a frame is in progress.
module axis_full_to_data_c #(
    parameter int unsigned DSIZE  = 8,
    parameter int unsigned KSIZE  = DSIZE / 8,
    parameter int unsigned USIZE  = 1,
    parameter int unsigned FCNT_W = 16
) (
    input  logic                             clock,
    input  logic                             rst,
    // axi_stream_inf slave side
    input  logic [DSIZE-1:0]                 axis_tdata_i,
    input  logic [KSIZE-1:0]                 axis_tkeep_i,
    input  logic [USIZE-1:0]                 axis_tuser_i,
    input  logic                             axis_tlast_i,
    input  logic                             axis_tvalid_i,
    output logic                             axis_tready_o,
    // data_inf_c master side
    output logic [USIZE+KSIZE+1+DSIZE-1:0]   data_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    // status
    output logic [FCNT_W-1:0]                frame_cnt_o,
    output logic                             in_frame_o
);

    localparam int unsigned W = USIZE + KSIZE + 1 + DSIZE;

    logic [W-1:0]      main_q, main_d;
    logic [W-1:0]      skid_q, skid_d;
    logic              m_v_q, m_v_d;
    logic              s_v_q, s_v_d;
    logic              rdy_q, rdy_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              in_frame_q, in_frame_d;

    logic [W-1:0] in_word;
    logic         acc;
    logic         ofire;

    assign in_word = {axis_tuser_i, axis_tkeep_i, axis_tlast_i, axis_tdata_i};
    assign acc     = axis_tvalid_i & rdy_q;
    assign ofire   = m_v_q & ready_i;

    // Skid-buffer next state; acc cannot coincide with s_v_q because rdy_q is low then
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        m_v_d  = m_v_q;
        s_v_d  = s_v_q;
        if (ofire && s_v_q) begin
            main_d = skid_q;
            m_v_d  = 1'b1;
            s_v_d  = 1'b0;
        end else if (acc && (!m_v_q || ofire)) begin
            main_d = in_word;
            m_v_d  = 1'b1;
        end else if (acc) begin
            skid_d = in_word;
            s_v_d  = 1'b1;
        end else if (ofire) begin
            m_v_d = 1'b0;
        end
        rdy_d = ~s_v_d;
    end

    // Frame counter and in-frame flag follow accepted beats only
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        in_frame_d  = in_frame_q;
        if (acc) begin
            if (axis_tlast_i) begin
                frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                in_frame_d  = 1'b0;
            end else begin
                in_frame_d = 1'b1;
            end
        end
    end

    // State registers; reset drops all buffered beats and status
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            main_q      <= '0;
            skid_q      <= '0;
            m_v_q       <= 1'b0;
            s_v_q       <= 1'b0;
            rdy_q       <= 1'b0;
            frame_cnt_q <= '0;
            in_frame_q  <= 1'b0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            m_v_q       <= m_v_d;
            s_v_q       <= s_v_d;
            rdy_q       <= rdy_d;
            frame_cnt_q <= frame_cnt_d;
            in_frame_q  <= in_frame_d;
        end
    end

    assign axis_tready_o = rdy_q;
    assign data_o        = main_q;
    assign valid_o       = m_v_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign in_frame_o    = in_frame_q;

endmodule

// File: tb/tb_axis_full_to_data_c.sv
// Bench for axis_full_to_data_c (DSIZE=8, USIZE=1, FCNT_W=4).
// Reference: a queue of beats in flight; valid = queue non-empty, tready = fewer than two held.
module tb_axis_full_to_data_c;

    localparam int unsigned W = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   tdata;
    logic [0:0]   tkeep;
    logic [0:0]   tuser;
    logic         tlast;
    logic         tvalid;
    logic         tready;
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic [3:0]   frame_cnt;
    logic         in_frame;

    axis_full_to_data_c #(
        .DSIZE (8),
        .KSIZE (1),
        .USIZE (1),
        .FCNT_W(4)
    ) dut (
        .clock        (clk),
        .rst          (rst),
        .axis_tdata_i (tdata),
        .axis_tkeep_i (tkeep),
        .axis_tuser_i (tuser),
        .axis_tlast_i (tlast),
        .axis_tvalid_i(tvalid),
        .axis_tready_o(tready),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .frame_cnt_o  (frame_cnt),
        .in_frame_o   (in_frame)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // reference model state
    logic [W-1:0] q[$];
    int unsigned  m_cnt;
    bit           m_inframe;
    bit           m_rdy_en;
    int unsigned  acc_count;

    typedef struct {
        logic       tuser;
        logic       tkeep;
        logic       tlast;
        logic [7:0] tdata;
        logic [W-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt     = 0;
        m_inframe = 0;
        m_rdy_en  = 0;
    endtask

    task automatic check_model();
        chk("valid", {31'd0, valid}, {31'd0, q.size() > 0});
        chk("tready", {31'd0, tready}, {31'd0, m_rdy_en && q.size() < 2});
        if (q.size() > 0) chk("data", {21'd0, data}, {21'd0, q[0]});
        chk("frame_cnt", {28'd0, frame_cnt}, m_cnt);
        chk("in_frame", {31'd0, in_frame}, {31'd0, m_inframe});
    endtask

    // One clock edge: predict handshakes from the model, advance it, then compare
    task automatic cycle();
        bit           m_tready;
        bit           acc;
        bit           ofire;
        logic [W-1:0] w;
        m_tready = m_rdy_en && (q.size() < 2);
        acc      = tvalid && m_tready;
        ofire    = (q.size() > 0) && ready;
        w        = {tuser, tkeep, tlast, tdata};
        @(posedge clk);
        if (ofire) void'(q.pop_front());
        if (acc) begin
            q.push_back(w);
            acc_count++;
            if (tlast) begin
                m_cnt     = (m_cnt + 1) % 16;
                m_inframe = 0;
            end else begin
                m_inframe = 1;
            end
        end
        m_rdy_en = 1;
        #1;
        check_model();
    endtask

    task automatic drive(input logic u, input logic k, input logic l, input logic [7:0] d);
        tvalid = 1'b1;
        tuser  = u;
        tkeep  = k;
        tlast  = l;
        tdata  = d;
    endtask

    vec_t vecs[5];

    initial begin
        int unsigned start;
        int unsigned cycles;
        acc_count = 0;
        model_reset();
        rst = 1'b1; tvalid = 0; tdata = 0; tkeep = 0; tuser = 0; tlast = 0; ready = 0;

        // reset state
        #12;
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_tready", {31'd0, tready}, 0);
        chk("rst_data", {21'd0, data}, 0);
        chk("rst_cnt", {28'd0, frame_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("tready_after_rst", {31'd0, tready}, 1);

        // streaming frame plus packing vector, ready held high
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h11, 11'h211};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h22, 11'h222};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h33, 11'h233};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h44, 11'h344};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h5A, 11'h55A};
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].tuser, vecs[i].tkeep, vecs[i].tlast, vecs[i].tdata);
            cycle();
            chk("tbl_data", {21'd0, data}, {21'd0, vecs[i].exp});
            chk("tbl_tready", {31'd0, tready}, 1);
            if (i == 3) chk("tbl_cnt", {28'd0, frame_cnt}, 1);
        end
        tvalid = 0;
        cycle();
        chk("tbl_drained", {31'd0, valid}, 0);

        // backpressure: A1 in main, A2 in skid, A3 held by source
        ready = 1'b0;
        drive(0, 1, 0, 8'hA1); cycle();
        chk("bp_a1", {21'd0, data}, 11'h2A1);
        drive(0, 1, 0, 8'hA2); cycle();
        chk("bp_full_tready", {31'd0, tready}, 0);
        drive(0, 1, 1, 8'hA3); cycle(); cycle();
        chk("bp_hold_data", {21'd0, data}, 11'h2A1);
        chk("bp_hold_tready", {31'd0, tready}, 0);
        ready = 1'b1; cycle();
        chk("bp_a2", {21'd0, data}, 11'h2A2);
        chk("bp_recover_tready", {31'd0, tready}, 1);
        cycle();
        chk("bp_a3", {21'd0, data}, 11'h3A3);
        tvalid = 0; cycle();
        chk("bp_empty", {31'd0, valid}, 0);

        // reset with both entries full
        ready = 1'b0;
        drive(0, 1, 0, 8'hB1); cycle();
        drive(0, 1, 0, 8'hB2); cycle();
        tvalid = 0;
        chk("full_valid", {31'd0, valid}, 1);
        chk("full_tready", {31'd0, tready}, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, valid}, 0);
        chk("arst_tready", {31'd0, tready}, 0);
        chk("arst_cnt", {28'd0, frame_cnt}, 0);
        chk("arst_in_frame", {31'd0, in_frame}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("arst_tready_back", {31'd0, tready}, 1);

        // counter wrap with single-beat frames
        ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(0, 1, 1, 8'(i));
            cycle();
            chk("wrap_cnt", {28'd0, frame_cnt}, (i + 1) % 16);
            chk("wrap_in_frame", {31'd0, in_frame}, 0);
        end
        tvalid = 0;
        cycle();

        // random traffic against the queue model
        start  = acc_count;
        cycles = 0;
        while ((acc_count - start) < 10000 && cycles < 60000) begin
            tvalid = 1'($urandom_range(0, 1));
            ready  = 1'($urandom_range(0, 1));
            tdata  = 8'($urandom);
            tkeep  = 1'($urandom);
            tuser  = 1'($urandom);
            tlast  = ($urandom_range(0, 3) == 0);
            cycle();
            cycles++;
        end
        chk("rand_beats", acc_count - start, 10000);
        tvalid = 0;
        ready  = 1'b1;
        repeat (3) cycle();
        chk("rand_drained", {31'd0, valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axis_full_to_data_c.md
# axis_full_to_data_c

Registered AXI-Stream to data_inf_c converter. It accepts beats on an axi_stream_inf slave port and packs tuser, tkeep, tlast and tdata into one data_inf_c word. A two-entry skid buffer breaks the valid path and the ready path, so both are fully registered. The block sits at stream-to-datapath boundaries where timing needs a register slice, and it also counts completed frames for status.

## Interface
Parameters:
- DSIZE, 8: axis_tdata width in bits; must be a multiple of 8.
- KSIZE, DSIZE/8: axis_tkeep width.
- USIZE, 1: axis_tuser width.
- FCNT_W, 16: frame counter width.

Ports:
- clock  input  1  block clock; both interfaces are synchronous to it.
- rst  input  1  reset, asynchronous and active-high.
- axis_in  axi_stream_inf.slaver  DSIZE/KSIZE/USIZE  input stream (tdata, tkeep, tuser, tlast, tvalid, tready).
- data_out_inf  data_inf_c.master  USIZE+KSIZE+1+DSIZE  output word (data, valid, ready).
- frame_cnt  output  FCNT_W  number of accepted tlast beats; wraps.
- in_frame  output  1  high when at least one beat of the current frame has been accepted and its tlast has not.

## Operation
- Packing order, MSB to LSB: data = {tuser, tkeep, tlast, tdata}. No field is altered.
- Storage is two registers: main (valid flag m_v plus payload) and skid (s_v plus payload).
- data_out_inf.valid = m_v. data_out_inf.data = main payload.
- axis_in.axis_tready is a registered flag rdy_r. Next value: rdy_r_next = !s_v_next.
- Input accept: acc = tvalid & rdy_r. Output fire: ofire = m_v & ready.
- Per-cycle update, evaluated in priority order:
  - If ofire and s_v: main <= skid, m_v=1, s_v=0. If acc also occurs in the same cycle, that beat goes to main only when skid was empty; otherwise it is impossible, because rdy_r=0.
  - Else if acc and (!m_v or ofire): main <= input beat, m_v=1.
  - Else if acc and m_v and !ofire: skid <= input beat, s_v=1.
  - Else if ofire: m_v=0.
- Beats are delivered in strict acceptance order. No beat is dropped or duplicated.
- frame_cnt increments by 1 on each acc with tlast=1, modulo 2^FCNT_W (0xFFFF wraps to 0x0000).
- in_frame is set on acc with tlast=0 and cleared on acc with tlast=1. A single-beat frame leaves it at 0.
- tkeep and tuser are carried without interpretation. A null beat (tkeep=0) is forwarded as-is.

## Timing
- Reset values, asynchronous: m_v=0, s_v=0, rdy_r=0, frame_cnt=0, in_frame=0. Payload registers are reset to 0.
- rdy_r rises to 1 on the first clock edge after rst deasserts.
- Latency: a beat accepted at edge N is visible on data_out_inf at edge N, so valid rises in cycle N+1. This is 1 cycle when ready is held high.
- Throughput: 1 beat per cycle with ready continuously high. axis_tready never drops in that case.
- Backpressure: if ready drops, main holds. One more beat can be absorbed into skid, then tready deasserts the following cycle. Nothing depends combinationally on ready or tvalid.
- Recovery: when ready returns, the skid beat moves to main on the same edge as the main beat fires. tready returns to 1 on that same edge.
- Full condition is m_v & s_v with tready=0. Empty condition is m_v=0 with valid=0.
- Output stability: once valid=1, data and valid hold until ofire.
- Reset mid-operation: buffered beats are discarded and valid drops immediately. The counters clear. A partially transferred frame is lost, and the upstream source is responsible for that.

## Test plan
- Reset: assert rst mid-stream with both entries full -> valid=0, tready=0, frame_cnt=0 asynchronously; tready=1 one edge after release.
- Streaming: DSIZE=8, ready=1, send 4-beat frame tdata 0x11,0x22,0x33,0x44, tkeep=1, tlast on the last beat -> data 0x0_1_0_11 ... 0x0_1_1_44 appear one cycle after each accept; tready stays 1; frame_cnt=1.
- Backpressure: hold ready=0 while sending 0xA1,0xA2,0xA3 -> 0xA1 held in main, 0xA2 in skid, tready=0, 0xA3 held by source; release ready -> output order 0xA1,0xA2,0xA3 with no gaps.
- Random: random tvalid and ready at 50% each for 10k beats with a scoreboard -> exact order match, and the valid/data-stable rule is never violated.
- Counter wrap: FCNT_W=4, send 17 single-beat frames (tlast=1) -> frame_cnt reaches 15, then 0, then 1; in_frame stays 0 throughout.
- Packing: USIZE=1, tuser=1, tkeep=0, tlast=1, tdata=0x5A -> data=0x1_0_1_5A (binary 1 0 1 01011010).
